// File: rtl/marquee_seq.sv
// marquee_seq: parametrised LED marquee sequencer.
// A prescaler produces a step tick every (DIV >> speed) cycles (minimum 1).
// On each tick the WIDTH-bit pattern rotates left, rotates right, bounces
// or performs a Johnson fill/empty, selected at run time by mode.
// Optional feature: define MARQUEE_PWM_EN to add a 4-bit duty input that
// dims the LEDs with a free-running 16-step PWM mask.
module marquee_seq #(
    parameter int               WIDTH = 12,
    parameter int               DIV   = 12500000,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
`ifdef MARQUEE_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             step_tick
);

    localparam int                CNT_W = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam logic [CNT_W-1:0]  DIV_C = CNT_W'(DIV);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [WIDTH-1:0] pattern, pattern_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    dir_t             dir, dir_nxt;
    logic             tick_nxt;
    logic [CNT_W-1:0] period, period_m1;

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] johnson(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ~v[WIDTH-1]};
    endfunction

    // Step period from the speed select, clamped so a tick can never be skipped.
    always_comb begin
        period = DIV_C >> speed;
        if (period == '0) begin
            period = CNT_W'(1);
        end
        period_m1 = period - CNT_W'(1);
    end

    // Next-state logic: seed load beats pause, pause beats normal stepping.
    always_comb begin
        pattern_nxt = pattern;
        cnt_nxt     = cnt;
        dir_nxt     = dir;
        tick_nxt    = 1'b0;
        if (seed_load) begin
            pattern_nxt = seed;
            cnt_nxt     = '0;
            dir_nxt     = DIR_LEFT;
        end else if (en) begin
            // >= rather than == so a mid-count speed-up ticks at once instead of wrapping
            if (cnt >= period_m1) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                dir_nxt  = DIR_LEFT;
                case (mode)
                    2'd0: pattern_nxt = rot_left(pattern);
                    2'd1: pattern_nxt = rot_right(pattern);
                    2'd2: begin
                        if (dir == DIR_LEFT && pattern[WIDTH-1]) begin
                            dir_nxt     = DIR_RIGHT;
                            pattern_nxt = rot_right(pattern);
                        end else if (dir == DIR_RIGHT && pattern[0]) begin
                            dir_nxt     = DIR_LEFT;
                            pattern_nxt = rot_left(pattern);
                        end else if (dir == DIR_RIGHT) begin
                            dir_nxt     = DIR_RIGHT;
                            pattern_nxt = rot_right(pattern);
                        end else begin
                            dir_nxt     = DIR_LEFT;
                            pattern_nxt = rot_left(pattern);
                        end
                    end
                    default: pattern_nxt = johnson(pattern);
                endcase
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset to the power-on pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern   <= SEED;
            cnt       <= '0;
            dir       <= DIR_LEFT;
            step_tick <= 1'b0;
        end else begin
            pattern   <= pattern_nxt;
            cnt       <= cnt_nxt;
            dir       <= dir_nxt;
            step_tick <= tick_nxt;
        end
    end

`ifdef MARQUEE_PWM_EN
    logic [3:0] pwm_cnt;

    // Free-running dimming counter, independent of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign Q = pattern & {WIDTH{pwm_cnt < duty}};
`else
    assign Q = pattern;
`endif

endmodule
